// File: rtl/riscv_pkg.sv
// Shared constants for the five-stage RISC-V core: writeback source encodings,
// load funct3 encodings and default datapath widths.
package riscv_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_REG_AW = 5;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_IMM  = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_writeback_load_extend.sv
// Combinational load-data extraction: picks the byte/half at the given offset,
// sign- or zero-extends it, and flags misaligned half/word accesses.
module load_extend
    import riscv_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        case (off)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            default: byte_s = word[31:24];
        endcase
        half_s = off[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data       = word;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){byte_s[7]}}, byte_s};
            F3_LBU: data = {{(XLEN-8){1'b0}}, byte_s};
            F3_LH: begin
                data       = {{(XLEN-16){half_s[15]}}, half_s};
                misaligned = off[0];
            end
            F3_LHU: begin
                data       = {{(XLEN-16){1'b0}}, half_s};
                misaligned = off[0];
            end
            // LW and the unused encodings all behave as a full-word load
            F3_LW: begin
                data       = word;
                misaligned = (off != 2'd0);
            end
            default: begin
                data       = word;
                misaligned = (off != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and writeback datapath driving the register-file write port.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module mem_wb_writeback
    import riscv_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [1:0]        mem_wb_sel,
    input  logic [2:0]        mem_funct3,
    input  logic [XLEN-1:0]   mem_alu_result,
    input  logic [XLEN-1:0]   mem_load_data,
    input  logic [XLEN-1:0]   mem_pc_plus4,
    input  logic [XLEN-1:0]   mem_imm,
    output logic              RegWrite,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   RegWriteData,
    output logic              wb_valid,
    output logic              misaligned_err
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]       instret
`endif
);

    logic              vld_p1;
    logic              reg_write_p1;
    logic [REG_AW-1:0] rd_p1;
    logic [1:0]        wb_sel_p1;
    logic [2:0]        funct3_p1;
    logic [XLEN-1:0]   alu_result_p1;
    logic [XLEN-1:0]   load_data_p1;
    logic [XLEN-1:0]   pc_plus4_p1;
    logic [XLEN-1:0]   imm_p1;

    // MEM -> WB stage boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1        <= 1'b0;
            reg_write_p1  <= 1'b0;
            rd_p1         <= '0;
            wb_sel_p1     <= '0;
            funct3_p1     <= '0;
            alu_result_p1 <= '0;
            load_data_p1  <= '0;
            pc_plus4_p1   <= '0;
            imm_p1        <= '0;
        end else if (flush) begin
            vld_p1       <= 1'b0;
            reg_write_p1 <= 1'b0;
        end else if (!stall) begin
            vld_p1        <= mem_valid;
            reg_write_p1  <= mem_reg_write;
            rd_p1         <= mem_rd;
            wb_sel_p1     <= mem_wb_sel;
            funct3_p1     <= mem_funct3;
            alu_result_p1 <= mem_alu_result;
            load_data_p1  <= mem_load_data;
            pc_plus4_p1   <= mem_pc_plus4;
            imm_p1        <= mem_imm;
        end
    end

    logic [XLEN-1:0] load_ext;
    logic            load_mis;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .funct3     (funct3_p1),
        .off        (alu_result_p1[1:0]),
        .word       (load_data_p1),
        .data       (load_ext),
        .misaligned (load_mis)
    );

    always_comb begin
        case (wb_sel_p1)
            WB_SEL_ALU:  RegWriteData = alu_result_p1;
            WB_SEL_LOAD: RegWriteData = load_ext;
            WB_SEL_PC4:  RegWriteData = pc_plus4_p1;
            default:     RegWriteData = imm_p1;
        endcase
    end

    // A held stall keeps RegWrite high with identical data; rewriting is harmless.
    assign misaligned_err = vld_p1 & (wb_sel_p1 == WB_SEL_LOAD) & load_mis;
    assign RegWrite       = vld_p1 & reg_write_p1 & (rd_p1 != '0) & ~misaligned_err;
    assign rd             = rd_p1;
    assign wb_valid       = vld_p1;

`ifdef WB_INSTRET_EN
    // Counts whatever leaves WB, even when a flush refills it the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            instret <= 64'd0;
        else if (vld_p1 && !stall)
            instret <= instret + 64'd1;
    end
`endif

endmodule
